// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX FIFO, single-byte RX holding register,
// software-writable baud divisor.
module uart_periph #(
  parameter logic [15:0] DIV_DEFAULT   = 16'd5208,
  parameter int          TX_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        tx,
  input  logic        rx
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int CW    = TX_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  logic [7:0]               r_fifo [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] r_wptr;
  logic [TX_DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]            r_count;
  logic [15:0]              r_div;

  tx_state_t   r_tx_state;
  logic [15:0] r_tx_div;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_byte;
  logic        r_tx;

  rx_state_t   r_rx_state;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic [15:0] r_rx_div;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid;
  logic        r_rx_overrun;
  logic        r_rx_ferr;

  logic w_wr;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_clr;
  logic w_tx_tick;
  logic w_rx_tick;
  logic w_rx_half;
  logic w_tx_busy;
  logic [15:0] w_status;

  assign w_wr    = sel & we;
  assign w_full  = r_count == CW'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_push  = w_wr && (addr == 2'd0) && !w_full;
  assign w_clr   = w_wr && (addr == 2'd2);

  assign w_tx_tick = r_tx_cnt == r_tx_div - 16'd1;
  assign w_rx_tick = r_rx_cnt == r_rx_div - 16'd1;
  assign w_rx_half = r_rx_cnt == (r_rx_div >> 1) - 16'd1;
  assign w_tx_busy = r_tx_state != TX_IDLE;

  // A STOP bit ending with data queued chains straight into the next START.
  assign w_pop = !w_empty &&
    (r_tx_state == TX_IDLE ||
     (r_tx_state == TX_STOP && w_tx_tick));

  assign w_status = {10'b0, r_rx_ferr, r_rx_overrun,
                     r_rx_valid, w_tx_busy, w_empty, w_full};

  assign tx = r_tx;

  always_comb begin
    dout = '0;
    if (sel) begin
      case (addr)
        2'd0: dout = '0;
        2'd1: dout = w_status;
        2'd2: dout = {8'b0, r_rx_byte};
        2'd3: dout = r_div;
        default: dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= DIV_DEFAULT;
    end else if (w_wr && addr == 2'd3) begin
      r_div <= (din < 16'd4) ? 16'd4 : din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= din[7:0];
        r_wptr <= r_wptr + TX_DEPTH_LOG2'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + TX_DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is driven from the state one edge late, so a frame starts at N+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_div   <= DIV_DEFAULT;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_byte  <= '0;
      r_tx       <= 1'b1;
    end else begin
      if (r_tx_state != TX_IDLE)
        r_tx_cnt <= w_tx_tick ? 16'd0 : r_tx_cnt + 16'd1;
      unique case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_tx_byte  <= r_fifo[r_rptr];
            r_tx_div   <= r_div;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          r_tx <= 1'b0;
          if (w_tx_tick) begin
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          r_tx <= r_tx_byte[r_tx_bit];
          if (w_tx_tick) begin
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7)
              r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          r_tx <= 1'b1;
          if (w_tx_tick) begin
            if (w_pop) begin
              r_tx_byte  <= r_fifo[r_rptr];
              r_tx_div   <= r_div;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_div     <= DIV_DEFAULT;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      if (w_clr) begin
        r_rx_valid   <= 1'b0;
        r_rx_overrun <= 1'b0;
        r_rx_ferr    <= 1'b0;
      end
      unique case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_div   <= r_div;
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_half) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7)
              r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            r_rx_cnt <= '0;
            if (r_rx_s2) begin
              // A completing byte beats a same-edge clear.
              r_rx_byte  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              if (r_rx_valid && !w_clr)
                r_rx_overrun <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_ferr  <= 1'b1;
              r_rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_s2)
            r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph: TX frame timing, FIFO overflow,
// RX flags, false starts and mid-frame reset.
module tb_uart_periph;

  localparam int DV = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [15:0] din;
  logic [15:0] dout;
  logic        tx;
  logic        rx;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  uart_periph dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; din = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = dout;
    sel = 1'b0;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int i);
    int j;
    j = (i % (10 * DV)) / DV;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(DV);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      cyc(DV);
    end
    rx = stop;
    cyc(DV);
    rx = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset = 1'b1; sel = 1'b0; we = 1'b0;
    addr = '0; din = '0; rx = 1'b1;
    cyc(3);
    reset = 1'b0;
    rd(2'd3, v); n_cmp++;
    if (v !== 16'd5208) begin
      n_err++; $display("FAIL reset_div got=%h exp=%h", v, 16'd5208);
    end
    rd(2'd1, v); n_cmp++;
    if (v !== 16'h0002) begin
      n_err++; $display("FAIL reset_status got=%h exp=0002", v);
    end
    rd(2'd2, v); n_cmp++;
    if (v !== 16'h0000) begin
      n_err++; $display("FAIL reset_rxdata got=%h exp=0000", v);
    end
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL reset_tx got=%b exp=1", tx);
    end
  endtask

  task automatic test_div;
    logic [15:0] v;
    wr(2'd3, 16'd2);
    rd(2'd3, v); n_cmp++;
    if (v !== 16'd4) begin
      n_err++; $display("FAIL div_clamp got=%0d exp=4", v);
    end
    wr(2'd3, 16'd8);
    rd(2'd3, v); n_cmp++;
    if (v !== 16'd8) begin
      n_err++; $display("FAIL div_write got=%0d exp=8", v);
    end
  endtask

  task automatic test_single_frame;
    logic [15:0] v;
    logic [7:0]  b;
    int bad;
    tx_q.push_back(8'hA5);
    wr(2'd0, 16'h00A5);
    cyc(1);
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL a5_latency tx got=%b exp=1 at N+1", tx);
    end
    b = tx_q.pop_front();
    bad = 0;
    for (int i = 0; i < 10 * DV; i++) begin
      cyc(1);
      if (tx !== fbit(b, i)) bad++;
      if (i == 10 * DV - 2) begin
        rd(2'd1, v); n_cmp++;
        if (v[2] !== 1'b1) begin
          n_err++; $display("FAIL a5_busy_end got=%b exp=1", v[2]);
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL a5_frame bad_cycles=%0d exp=0", bad);
    end
    rd(2'd1, v); n_cmp++;
    if (v !== 16'h0002) begin
      n_err++; $display("FAIL a5_status_idle got=%h exp=0002", v);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    logic [7:0]  b;
    int bad;
    int idle_bad;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          if (k < 5) tx_q.push_back(8'hC0 + 8'(k * 7));
          wr(2'd0, {8'h00, 8'hC0 + 8'(k * 7)});
          if (k == 4) begin
            rd(2'd1, v); n_cmp++;
            if (v[0] !== 1'b1) begin
              n_err++; $display("FAIL b2b_full got=%b exp=1", v[0]);
            end
          end
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        b = '0;
        bad = 0;
        for (int i = 0; i < 50 * DV; i++) begin
          if (i % (10 * DV) == 0) begin
            if (tx_q.size() != 0) b = tx_q.pop_front();
            bad = 0;
          end
          if (tx !== fbit(b, i)) bad++;
          if (i % (10 * DV) == 10 * DV - 1) begin
            n_cmp++;
            if (bad != 0) begin
              n_err++;
              $display("FAIL b2b_frame%0d byte=%h bad_cycles=%0d exp=0",
                       i / (10 * DV), b, bad);
            end
          end
          cyc(1);
        end
      end
    join
    rd(2'd1, v); n_cmp++;
    if (v !== 16'h0002) begin
      n_err++; $display("FAIL b2b_status_end got=%h exp=0002", v);
    end
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) idle_bad++;
      cyc(1);
    end
    n_cmp++;
    if (idle_bad != 0) begin
      n_err++; $display("FAIL b2b_sixth_dropped low_cycles=%0d exp=0", idle_bad);
    end
  endtask

  task automatic chk_rx(input string nm, input logic [15:0] st_exp);
    logic [15:0] v;
    logic [7:0]  e;
    rd(2'd1, v); n_cmp++;
    if (v !== st_exp) begin
      n_err++; $display("FAIL %s_status got=%h exp=%h", nm, v, st_exp);
    end
    if (rx_q.size() != 0) begin
      e = rx_q.pop_front();
      rd(2'd2, v); n_cmp++;
      if (v !== {8'h00, e}) begin
        n_err++; $display("FAIL %s_rxdata got=%h exp=%h", nm, v, {8'h00, e});
      end
    end
  endtask

  task automatic test_rx;
    logic [15:0] v;
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    chk_rx("rx3c", 16'h000A);
    rx_q.push_back(8'h55);
    send_rx(8'h55, 1'b1);
    chk_rx("rx55_overrun", 16'h001A);
    wr(2'd2, 16'h0000);
    chk_rx("rx_clear", 16'h0002);
    rx_q.push_back(8'h81);
    send_rx(8'h81, 1'b1);
    chk_rx("rx81", 16'h000A);
    send_rx(8'h7E, 1'b0);
    chk_rx("rx_ferr", 16'h002A);
    rd(2'd2, v); n_cmp++;
    if (v !== 16'h0081) begin
      n_err++; $display("FAIL rx_ferr_keep got=%h exp=0081", v);
    end
  endtask

  task automatic test_glitch;
    wr(2'd2, 16'h0000);
    rx = 1'b0;
    cyc(2);
    rx = 1'b1;
    cyc(20);
    chk_rx("glitch", 16'h0002);
    rx_q.push_back(8'h96);
    send_rx(8'h96, 1'b1);
    chk_rx("after_glitch", 16'h000A);
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    int bad;
    wr(2'd0, 16'h005A);
    wr(2'd0, 16'h006B);
    cyc(30);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_tx got=%b exp=1", tx);
    end
    rd(2'd1, v); n_cmp++;
    if (v !== 16'h0002) begin
      n_err++; $display("FAIL rst_mid_status got=%h exp=0002", v);
    end
    rd(2'd3, v); n_cmp++;
    if (v !== 16'd5208) begin
      n_err++; $display("FAIL rst_mid_div got=%0d exp=5208", v);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) bad++;
      cyc(1);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_mid_fifo_flushed low_cycles=%0d exp=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_single_frame();
    test_back_to_back();
    test_rx();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
